// File: rtl/convolutor_ctrl_pkg.sv
// Shared definitions for the 1-D convolution sequencer.
//   state_t        : sequencer states
//   ADDR_W_DEFAULT : default width of the X/Y address buses and size inputs
package convolutor_ctrl_pkg;

    localparam int unsigned ADDR_W_DEFAULT = 5;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        CALC  = 3'd2,
        WAIT  = 3'd3,
        STORE = 3'd4,
        DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/convolutor_index_counter.sv
// Up-counter with synchronous clear, count enable and terminal-value flag.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clr_i         : load zero (has priority over en_i)
//   en_i          : increment by one
//   last_i        : terminal value to compare against
//   cnt_o         : current count
//   at_last_o     : cnt_o == last_i
module convolutor_index_counter #(
    parameter int unsigned WIDTH = 5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] last_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             at_last_o
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + WIDTH'(1);
        end
    end

    assign cnt_o = cnt_q;

    convolutor_std_comparator_p #(
        .WIDTH (WIDTH),
        .TYPE  (0)
    ) u_last_cmp (
        .a_i (cnt_q),
        .b_i (last_i),
        .y_o (at_last_o)
    );

endmodule

// File: rtl/convolutor_std_comparator_p.sv
// Parametric combinational comparator.
//   a_i, b_i : unsigned operands, WIDTH bits
//   y_o      : result of the comparison selected by TYPE
//              0: a==b  1: a!=b  2: a<b  3: a<=b  4: a>b  5: a>=b
module convolutor_std_comparator_p #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned TYPE  = 0
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             y_o
);

    always_comb begin
        y_o = 1'b0;
        case (TYPE)
            0:       y_o = (a_i == b_i);
            1:       y_o = (a_i != b_i);
            2:       y_o = (a_i <  b_i);
            3:       y_o = (a_i <= b_i);
            4:       y_o = (a_i >  b_i);
            5:       y_o = (a_i >= b_i);
            default: y_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/convolutor_ctrl_fsm.sv
// Sequencer for the 1-D convolution datapath: Z[i] = sum_j X[i-j]*Y[j].
//   clk_i, rst_ni      : clock, asynchronous active-low reset
//   start_i            : start request (IDLE only); size_x_i/size_y_i latched with it
//   busy_o, done_o     : operation in progress / one-cycle completion pulse
//   err_o              : zero-size request, sticky until the next accepted start
//   mem_x_addr_o       : X read address (i-j); mem_y_addr_o : Y read address (j)
//   mac_clr_o          : clear accumulator; mac_en_o : accumulate current read data
//   mem_z_addr_o       : Z write address (i); mem_z_we_o : Z write strobe
module convolutor_ctrl_fsm
    import convolutor_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] size_x_i,
    input  logic [ADDR_W-1:0] size_y_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [ADDR_W-1:0] mem_x_addr_o,
    output logic [ADDR_W-1:0] mem_y_addr_o,
    output logic              mac_clr_o,
    output logic              mac_en_o,
    output logic [ADDR_W:0]   mem_z_addr_o,
    output logic              mem_z_we_o
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] size_x_q, size_y_q;
    logic              err_q, err_d;
    logic              valid_q;
    logic [ADDR_W-1:0] x_hold_q, y_hold_q;
    logic [ADDR_W:0]   z_hold_q;

    logic [ADDR_W:0]   i_cnt, last_i, diff;
    logic [ADDR_W-1:0] j_cnt, last_j;
    logic              i_last, j_last, i_ge_j, diff_lt_x;
    logic              start_ok, zero_size;

    assign start_ok  = (state_q == IDLE) && start_i;
    assign zero_size = (size_x_i == '0) || (size_y_i == '0);
    assign last_i    = {1'b0, size_x_q} + {1'b0, size_y_q} - (ADDR_W+1)'(2);
    assign last_j    = size_y_q - ADDR_W'(1);
    assign diff      = i_cnt - {1'b0, j_cnt};

    convolutor_index_counter #(
        .WIDTH (ADDR_W + 1)
    ) u_i_cnt (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clr_i     (start_ok),
        .en_i      ((state_q == STORE) && !i_last),
        .last_i    (last_i),
        .cnt_o     (i_cnt),
        .at_last_o (i_last)
    );

    convolutor_index_counter #(
        .WIDTH (ADDR_W)
    ) u_j_cnt (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clr_i     (state_q == CLR),
        .en_i      ((state_q == CALC) && !j_last),
        .last_i    (last_j),
        .cnt_o     (j_cnt),
        .at_last_o (j_last)
    );

    convolutor_std_comparator_p #(
        .WIDTH (ADDR_W + 1),
        .TYPE  (5)
    ) u_ge_cmp (
        .a_i (i_cnt),
        .b_i ({1'b0, j_cnt}),
        .y_o (i_ge_j)
    );

    // diff wraps when i<j; the i>=j term masks that case.
    convolutor_std_comparator_p #(
        .WIDTH (ADDR_W + 1),
        .TYPE  (2)
    ) u_lt_cmp (
        .a_i (diff),
        .b_i ({1'b0, size_x_q}),
        .y_o (diff_lt_x)
    );

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    err_d   = zero_size;
                    state_d = zero_size ? DONE : CLR;
                end
            end
            CLR:     state_d = CALC;
            CALC:    state_d = j_last ? WAIT : CALC;
            WAIT:    state_d = STORE;
            STORE:   state_d = i_last ? DONE : CLR;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            size_x_q <= '0;
            size_y_q <= '0;
            err_q    <= 1'b0;
            valid_q  <= 1'b0;
            x_hold_q <= '0;
            y_hold_q <= '0;
            z_hold_q <= '0;
        end else begin
            state_q  <= state_d;
            err_q    <= err_d;
            // Read data arrives one cycle after the address, so the enable lags by one.
            valid_q  <= (state_q == CALC) && i_ge_j && diff_lt_x;
            x_hold_q <= mem_x_addr_o;
            y_hold_q <= mem_y_addr_o;
            z_hold_q <= mem_z_addr_o;
            if (start_ok) begin
                size_x_q <= size_x_i;
                size_y_q <= size_y_i;
            end
        end
    end

    assign busy_o       = (state_q == CLR) || (state_q == CALC) ||
                          (state_q == WAIT) || (state_q == STORE);
    assign done_o       = (state_q == DONE);
    assign err_o        = err_q;
    assign mac_clr_o    = (state_q == CLR);
    assign mac_en_o     = valid_q;
    assign mem_z_we_o   = (state_q == STORE);
    assign mem_x_addr_o = (state_q == CALC)  ? diff[ADDR_W-1:0] : x_hold_q;
    assign mem_y_addr_o = (state_q == CALC)  ? j_cnt            : y_hold_q;
    assign mem_z_addr_o = (state_q == STORE) ? i_cnt            : z_hold_q;

endmodule

// File: tb/tb_convolutor_ctrl_fsm.sv
module tb_convolutor_ctrl_fsm;

    localparam int unsigned AW = 5;

    typedef struct packed {
        logic          busy;
        logic          done;
        logic          clr;
        logic          en;
        logic          we;
        logic          err;
        logic [AW-1:0] xa;
        logic [AW-1:0] ya;
        logic [AW:0]   za;
    } out_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] sx_in = '0;
    logic [AW-1:0] sy_in = '0;
    logic          busy, done, err, mac_clr, mac_en, z_we;
    logic [AW-1:0] xa, ya;
    logic [AW:0]   za;

    int   errors = 0;
    int   checks = 0;
    out_t ex[$];
    out_t msk[$];
    out_t obs[$];
    logic exp_err;

    always #5 clk = ~clk;

    convolutor_ctrl_fsm #(
        .ADDR_W (AW)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .size_x_i     (sx_in),
        .size_y_i     (sy_in),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err),
        .mem_x_addr_o (xa),
        .mem_y_addr_o (ya),
        .mac_clr_o    (mac_clr),
        .mac_en_o     (mac_en),
        .mem_z_addr_o (za),
        .mem_z_we_o   (z_we)
    );

    function automatic bit x_valid(input int i, input int j, input int sx);
        return (i >= j) && ((i - j) < sx);
    endfunction

    task automatic push(input logic b, input logic d, input logic c, input logic e,
                        input logic w, input logic [AW-1:0] x, input logic [AW-1:0] y,
                        input logic [AW:0] z, input bit mxy, input bit mz);
        out_t v;
        out_t m;
        v.busy = b; v.done = d; v.clr = c; v.en = e; v.we = w; v.err = exp_err;
        v.xa = x; v.ya = y; v.za = z;
        m = '1;
        m.xa = mxy ? '1 : '0;
        m.ya = mxy ? '1 : '0;
        m.za = mz ? '1 : '0;
        ex.push_back(v);
        msk.push_back(m);
    endtask

    // Expected per-cycle outputs, cycle 1 after the accepting edge onward, plus one idle cycle.
    task automatic build_model(input int sx, input int sy);
        ex.delete();
        msk.delete();
        exp_err = (sx == 0) || (sy == 0);
        if (!exp_err) begin
            for (int i = 0; i < sx + sy - 1; i++) begin
                push(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
                for (int j = 0; j < sy; j++)
                    push(1'b1, 1'b0, 1'b0, (j > 0) && x_valid(i, j - 1, sx), 1'b0,
                         AW'(i - j), AW'(j), '0, 1'b1, 1'b0);
                push(1'b1, 1'b0, 1'b0, x_valid(i, sy - 1, sx), 1'b0, '0, '0, '0, 1'b0, 1'b0);
                push(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, '0, '0, (AW+1)'(i), 1'b0, 1'b1);
            end
        end
        push(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
        push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic capture(input int sx, input int sy, input bit hold, input bit toggle,
                           input int n);
        out_t o;
        obs.delete();
        @(negedge clk);
        start = 1'b1;
        sx_in = AW'(sx);
        sy_in = AW'(sy);
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            o.busy = busy; o.done = done; o.clr = mac_clr; o.en = mac_en; o.we = z_we;
            o.err = err; o.xa = xa; o.ya = ya; o.za = za;
            obs.push_back(o);
            if (toggle) begin
                sx_in = AW'($urandom);
                sy_in = AW'($urandom);
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, err, mac_clr, mac_en, z_we, xa, ya, za} !== '0) begin
            errors++;
            $display("FAIL reset_state: got %h want 0",
                     {busy, done, err, mac_clr, mac_en, z_we, xa, ya, za});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_reset_mid;
        int seen_done = 0;
        @(negedge clk);
        start = 1'b1; sx_in = 5'd4; sy_in = 5'd3;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, err, mac_clr, mac_en, z_we, xa, ya, za} !== '0) begin
            errors++;
            $display("FAIL reset_mid_async: got %h want 0",
                     {busy, done, err, mac_clr, mac_en, z_we, xa, ya, za});
        end
        repeat (3) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        checks++;
        if (seen_done !== 0) begin
            errors++;
            $display("FAIL reset_mid_no_done: got %0d done cycles want 0", seen_done);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        int stores = 0;
        int clears = 0;
        int busy_n = 0;
        int done_at = -1;
        build_model(4, 3);
        capture(4, 3, 1'b0, 1'b0, ex.size());
        for (int k = 0; k < ex.size(); k++) begin
            checks++;
            if ((obs[k] & msk[k]) !== (ex[k] & msk[k])) begin
                errors++;
                $display("FAIL basic_trace cycle %0d: got %h want %h mask %h",
                         k + 1, obs[k], ex[k], msk[k]);
            end
        end
        for (int k = 0; k < obs.size(); k++) begin
            stores += int'(obs[k].we);
            clears += int'(obs[k].clr);
            busy_n += int'(obs[k].busy);
            if (obs[k].done && done_at < 0) done_at = k + 1;
        end
        checks++;
        if (stores !== 6) begin
            errors++; $display("FAIL basic_stores: got %0d want 6", stores);
        end
        checks++;
        if (clears !== 6) begin
            errors++; $display("FAIL basic_clears: got %0d want 6", clears);
        end
        checks++;
        if (busy_n !== 36 || obs[0].busy !== 1'b1 || obs[35].busy !== 1'b1) begin
            errors++; $display("FAIL basic_busy: got %0d busy cycles want 36", busy_n);
        end
        checks++;
        if (done_at !== 37) begin
            errors++; $display("FAIL basic_done_cycle: got %0d want 37", done_at);
        end
        checks++;
        if ({obs[2].en, obs[3].en, obs[4].en} !== 3'b100) begin
            errors++;
            $display("FAIL basic_en_i0: got %b want 100", {obs[2].en, obs[3].en, obs[4].en});
        end
        checks++;
        if ({obs[32].en, obs[33].en, obs[34].en} !== 3'b001 || obs[33].xa !== 5'd3) begin
            errors++;
            $display("FAIL basic_en_i5: got %b xa %0d want 001 xa 3",
                     {obs[32].en, obs[33].en, obs[34].en}, obs[33].xa);
        end
    endtask

    task automatic test_single;
        build_model(1, 1);
        capture(1, 1, 1'b0, 1'b0, ex.size());
        checks++;
        if (obs[4].done !== 1'b1 || obs[3].we !== 1'b1 || obs[3].za !== 6'd0) begin
            errors++;
            $display("FAIL single_done5: got done %b we %b za %0d want 1 1 0",
                     obs[4].done, obs[3].we, obs[3].za);
        end
        for (int k = 0; k < ex.size(); k++) begin
            checks++;
            if ((obs[k] & msk[k]) !== (ex[k] & msk[k])) begin
                errors++;
                $display("FAIL single_trace cycle %0d: got %h want %h", k + 1, obs[k], ex[k]);
            end
        end
    endtask

    task automatic test_zero_size;
        int sxs[3] = '{3, 0, 2};
        int sys[3] = '{0, 5, 2};
        for (int r = 0; r < 3; r++) begin
            build_model(sxs[r], sys[r]);
            capture(sxs[r], sys[r], 1'b0, 1'b0, ex.size());
            for (int k = 0; k < ex.size(); k++) begin
                checks++;
                if ((obs[k] & msk[k]) !== (ex[k] & msk[k])) begin
                    errors++;
                    $display("FAIL zero_size run %0d cycle %0d: got %h want %h",
                             r, k + 1, obs[k], ex[k]);
                end
            end
        end
    endtask

    task automatic test_hold_start;
        int sxs[2] = '{5, 31};
        int sys[2] = '{4, 31};
        int last_z;
        for (int r = 0; r < 2; r++) begin
            build_model(sxs[r], sys[r]);
            capture(sxs[r], sys[r], 1'b1, 1'b1, ex.size());
            for (int k = 0; k < ex.size(); k++) begin
                checks++;
                if ((obs[k] & msk[k]) !== (ex[k] & msk[k])) begin
                    errors++;
                    $display("FAIL hold_start run %0d cycle %0d: got %h want %h",
                             r, k + 1, obs[k], ex[k]);
                end
            end
        end
        last_z = -1;
        for (int k = 0; k < obs.size(); k++)
            if (obs[k].we) last_z = int'(obs[k].za);
        checks++;
        if (last_z !== 60) begin
            errors++; $display("FAIL max_last_z: got %0d want 60", last_z);
        end
    endtask

    task automatic test_random;
        int sx, sy;
        for (int r = 0; r < 10; r++) begin
            sx = int'($urandom_range(0, 9));
            sy = int'($urandom_range(0, 7));
            build_model(sx, sy);
            capture(sx, sy, 1'b0, 1'b0, ex.size());
            for (int k = 0; k < ex.size(); k++) begin
                checks++;
                if ((obs[k] & msk[k]) !== (ex[k] & msk[k])) begin
                    errors++;
                    $display("FAIL random sx=%0d sy=%0d cycle %0d: got %h want %h",
                             sx, sy, k + 1, obs[k], ex[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_basic();
        test_single();
        test_zero_size();
        test_hold_start();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
